// File: rtl/uart_cmd_pkg.sv
// Shared state, command-range and response-code definitions for uart_cmd_loader.
// The S_CSUM state exists only when UART_CMD_CSUM_EN is defined.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_WR,
`ifdef UART_CMD_CSUM_EN
    S_CSUM,
`endif
    S_RESP
  } state_t;

  localparam logic [3:0] CMD_WRITE = 4'h0;
  localparam logic [3:0] CMD_FILL  = 4'h1;
  localparam logic [3:0] CMD_MODE  = 4'h3;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_CAN = 8'h18;

  localparam int CNT_BYTES = 2;

endpackage

// File: rtl/uart_cmd_shreg.sv
// Little-endian byte assembler: first loaded byte lands in q[7:0].
// full is high on the load that completes the word; the counter then rewraps.
module uart_cmd_shreg
  import uart_cmd_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [7:0]          din,
  output logic [8*NBYTES-1:0] q,
  output logic                full
);

  localparam int NW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [NW-1:0]        n;
  logic [8*NBYTES+7:0]  ext;

  assign ext  = {din, q};
  assign full = load && (n == NW'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
      n <= '0;
    end else if (load) begin
      q <= ext[8*NBYTES+7:8];
      n <= full ? '0 : n + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_loader.sv
// UART byte stream to channel word writes / mode updates, with fill and timeout.
// Define UART_CMD_CSUM_EN to require a trailing per-packet checksum byte.
module uart_cmd_loader
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_BYTES  = 2,
  parameter int NCHAN       = 3,
  parameter int TIMEOUT_CYC = 27_000_000,
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_data_valid,
  output logic                    rx_data_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_data_valid,
  input  logic                    tx_data_ready,
  output logic [CW-1:0]           wr_chan,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    wr_en,
  input  logic                    wr_ready,
  output logic [3:0]              mode,
  output logic                    mode_stb,
  output logic                    busy
);

  localparam int AB = (ADDR_W + 7) / 8;
  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t state;

  logic          acc;
  logic          wr_done;
  logic          idle;
  logic          timed;
  logic          tmo_hit;
  logic [TW-1:0] tmo;

  logic [8*AB-1:0] addr_q;
  logic            addr_full;
  logic [15:0]     cnt_q;
  logic            cnt_full;
  logic [DW-1:0]   data_q;
  logic            data_full;

  logic [15:0] words;
  logic        fill;
  logic        started;

  logic [3:0] cidx;
  logic       chan_ok;
  logic       is_wr;
  logic       is_fill;
  logic       is_mode;

`ifdef UART_CMD_CSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_nxt;
  assign sum_nxt = sum + rx_data;
`endif

  assign idle          = (state == S_IDLE);
  assign busy          = !idle;
  assign wr_en         = (state == S_WR);
  assign tx_data_valid = (state == S_RESP);
  assign rx_data_ready = !(wr_en || tx_data_valid);
  assign acc           = rx_data_valid && rx_data_ready;
  assign wr_done       = wr_en && wr_ready;
  assign wr_data       = data_q;

  assign cidx    = rx_data[3:0] - 4'd1;
  assign chan_ok = (rx_data[3:0] != 4'd0) && (32'(cidx) < NCHAN);
  assign is_wr   = (rx_data[7:4] == CMD_WRITE) && chan_ok;
  assign is_fill = (rx_data[7:4] == CMD_FILL) && chan_ok;
  assign is_mode = (rx_data[7:4] == CMD_MODE);

  always_comb begin
    timed = 1'b0;
    if (state == S_ADDR || state == S_CNT || state == S_DATA)
      timed = 1'b1;
`ifdef UART_CMD_CSUM_EN
    if (state == S_CSUM)
      timed = 1'b1;
`endif
  end

  // The abort fires on the cycle the idle count would reach TIMEOUT_CYC.
  assign tmo_hit = timed && !acc && (tmo == TW'(TIMEOUT_CYC - 1));

  uart_cmd_shreg #(.NBYTES(AB)) u_addr (
    .clk   (clk),
    .rst   (rst),
    .clear (idle),
    .load  (acc && state == S_ADDR),
    .din   (rx_data),
    .q     (addr_q),
    .full  (addr_full)
  );

  uart_cmd_shreg #(.NBYTES(CNT_BYTES)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (idle),
    .load  (acc && state == S_CNT),
    .din   (rx_data),
    .q     (cnt_q),
    .full  (cnt_full)
  );

  uart_cmd_shreg #(.NBYTES(DATA_BYTES)) u_data (
    .clk   (clk),
    .rst   (rst),
    .clear (idle),
    .load  (acc && state == S_DATA),
    .din   (rx_data),
    .q     (data_q),
    .full  (data_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_data  <= '0;
      wr_chan  <= '0;
      wr_addr  <= '0;
      words    <= '0;
      fill     <= 1'b0;
      started  <= 1'b0;
      mode     <= '0;
      mode_stb <= 1'b0;
      tmo      <= '0;
`ifdef UART_CMD_CSUM_EN
      sum      <= '0;
`endif
    end else begin
      mode_stb <= 1'b0;
      if (acc || !timed)
        tmo <= '0;
      else
        tmo <= tmo + 1'b1;
`ifdef UART_CMD_CSUM_EN
      if (acc)
        sum <= idle ? rx_data : sum_nxt;
`endif
      if (tmo_hit) begin
        tx_data <= RSP_CAN;
        state   <= S_RESP;
      end else begin
        unique case (state)
          S_IDLE: begin
            started <= 1'b0;
            if (acc) begin
              unique case (1'b1)
                is_wr || is_fill: begin
                  fill    <= is_fill;
                  wr_chan <= cidx[CW-1:0];
                  state   <= S_ADDR;
                end
                is_mode: begin
                  mode     <= rx_data[3:0];
                  mode_stb <= 1'b1;
                  tx_data  <= RSP_ACK;
                  state    <= S_RESP;
                end
                default: begin
                  tx_data <= RSP_NAK;
                  state   <= S_RESP;
                end
              endcase
            end
          end
          S_ADDR: begin
            if (acc && addr_full)
              state <= S_CNT;
          end
          S_CNT: begin
            wr_addr <= addr_q[ADDR_W-1:0];
            if (acc && cnt_full)
              state <= S_DATA;
          end
          S_DATA: begin
            if (!started) begin
              words   <= cnt_q;
              started <= 1'b1;
            end
            if (acc && data_full)
              state <= S_WR;
          end
          S_WR: begin
            if (wr_done) begin
              wr_addr <= wr_addr + 1'b1;
              if (words == 16'd0) begin
`ifdef UART_CMD_CSUM_EN
                state <= S_CSUM;
`else
                tx_data <= RSP_ACK;
                state   <= S_RESP;
`endif
              end else begin
                words <= words - 16'd1;
                state <= fill ? S_WR : S_DATA;
              end
            end
          end
`ifdef UART_CMD_CSUM_EN
          S_CSUM: begin
            if (acc) begin
              tx_data <= (sum_nxt == 8'h00) ? RSP_ACK : RSP_NAK;
              state   <= S_RESP;
            end
          end
`endif
          S_RESP: begin
            if (tx_data_ready)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Randomised bench for uart_cmd_loader against a packet-level reference model.
// Honours UART_CMD_CSUM_EN to append checksum bytes.
module tb_uart_cmd_loader;

  localparam int NCH = 3;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready = 1'b0;
  logic [1:0]  wr_chan;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_ready = 1'b0;
  logic [3:0]  mode;
  logic        mode_stb;
  logic        busy;

  uart_cmd_loader #(
    .ADDR_W(16), .DATA_BYTES(2), .NCHAN(NCH), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .wr_chan(wr_chan), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .wr_ready(wr_ready),
    .mode(mode), .mode_stb(mode_stb), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [3:0] exp_mode[$];
  logic [7:0] pkt[$];
  logic [15:0] words[$];

  int errors = 0;
  int checks = 0;
  bit hold = 0;
  bit force_hi = 0;

  task automatic chk_eq(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ready drivers change at posedge+1 so the negedge monitor sees stable values.
  initial forever begin
    @(posedge clk); #1;
    wr_ready = hold ? 1'b0 : force_hi ? 1'b1 : (($urandom % 4) != 0);
    tx_data_ready = ($urandom % 3) != 0;
  end

  logic        stall_prev = 0;
  logic [33:0] stall_val;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk_eq("wr_stable", {wr_en, wr_chan, wr_addr, wr_data}, {1'b1, stall_val});
      end
      stall_prev = wr_en && !wr_ready;
      stall_val = {wr_chan, wr_addr, wr_data};
      if (wr_en || tx_data_valid)
        chk_eq("rx_ready_blocked", rx_data_ready, 0);
      if (wr_en && wr_ready) begin
        if (exp_wr.size() == 0)
          chk_eq("wr_unexpected", {wr_chan, wr_addr, wr_data}, 0);
        else
          chk_eq("wr", {wr_chan, wr_addr, wr_data}, exp_wr.pop_front());
      end
      if (tx_data_valid && tx_data_ready) begin
        if (exp_tx.size() == 0)
          chk_eq("tx_unexpected", tx_data, 0);
        else
          chk_eq("tx", tx_data, exp_tx.pop_front());
      end
      if (mode_stb) begin
        if (exp_mode.size() == 0)
          chk_eq("mode_unexpected", mode, 16);
        else
          chk_eq("mode", mode, exp_mode.pop_front());
      end
    end
  end

  // Packet-level reference: bytes to send plus expected writes/responses.
  task automatic build(input logic [7:0] cmd, input logic [15:0] a,
                       input logic [15:0] n, input bit bad_csum);
    int ch;
    bit isw;
    bit isf;
    logic [7:0] s;
    pkt.delete();
    pkt.push_back(cmd);
    isw = (cmd[7:4] == 4'h0);
    isf = (cmd[7:4] == 4'h1);
    ch = int'(cmd[3:0]) - 1;
    if (cmd[7:4] == 4'h3) begin
      exp_mode.push_back(cmd[3:0]);
      exp_tx.push_back(8'h06);
    end else if (!(isw || isf) || ch < 0 || ch >= NCH) begin
      exp_tx.push_back(8'h15);
    end else begin
      pkt.push_back(a[7:0]);
      pkt.push_back(a[15:8]);
      pkt.push_back(n[7:0]);
      pkt.push_back(n[15:8]);
      for (int i = 0; i <= int'(n); i++) begin
        wr_t w;
        w.ch = ch[1:0];
        w.a = a + 16'(i);
        w.d = isw ? words[i] : words[0];
        exp_wr.push_back(w);
        if (isw || i == 0) begin
          pkt.push_back(w.d[7:0]);
          pkt.push_back(w.d[15:8]);
        end
      end
`ifdef UART_CMD_CSUM_EN
      s = 8'h00;
      foreach (pkt[k]) s = s + pkt[k];
      s = 8'h00 - s + (bad_csum ? 8'h01 : 8'h00);
      pkt.push_back(s);
      exp_tx.push_back(bad_csum ? 8'h15 : 8'h06);
`else
      s = {7'd0, bad_csum};
      exp_tx.push_back(8'h06 | (s & 8'h00));
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rx_data = b;
    rx_data_valid = 1'b1;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = rx_data_ready;
      @(posedge clk); #1;
    end
    rx_data_valid = 1'b0;
    if (!ok) chk_eq("rx_accept_timeout", 0, 1);
  endtask

  task automatic send_pkt();
    foreach (pkt[k]) send_byte(pkt[k]);
  endtask

  task automatic wait_idle(input int lim);
    bit ok = 0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      ok = !busy && exp_tx.size() == 0 && exp_wr.size() == 0;
    end
    @(posedge clk); #1;
    chk_eq("idle", ok, 1);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i <= n; i++) words.push_back(16'($urandom));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_eq("rst_outputs",
           {rx_data_ready, tx_data_valid, wr_en, mode_stb, busy, mode},
           {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
    chk_eq("rst_data", {tx_data, wr_chan, wr_addr, wr_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    words.delete();
    words.push_back(16'hBBAA);
    words.push_back(16'hDDCC);
    build(8'h02, 16'h1234, 16'd1, 0);
    chk_eq("model_w0", exp_wr[0], {2'd1, 16'h1234, 16'hBBAA});
    chk_eq("model_w1", exp_wr[1], {2'd1, 16'h1235, 16'hDDCC});
    chk_eq("model_b5", pkt[5], 8'hAA);
    send_pkt();
    wait_idle(500);

    force_hi = 1;
    words.delete();
    words.push_back(16'h5A5A);
    build(8'h11, 16'hFFFF, 16'd2, 0);
    chk_eq("model_f1", exp_wr[1], {2'd0, 16'h0000, 16'h5A5A});
    chk_eq("model_f2", exp_wr[2], {2'd0, 16'h0001, 16'h5A5A});
    send_pkt();
    begin
      bit seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge clk);
        seen = wr_en;
      end
      @(negedge clk);
      chk_eq("fill_b2b_1", {wr_en, wr_addr}, {1'b1, 16'h0000});
      @(negedge clk);
      chk_eq("fill_b2b_2", {wr_en, wr_addr}, {1'b1, 16'h0001});
    end
    wait_idle(500);
    force_hi = 0;

    rand_words(3);
    build(8'h01, 16'h0100, 16'd3, 0);
    fork
      send_pkt();
      begin
        bit seen = 0;
        for (int k = 0; k < 500 && !seen; k++) begin
          @(negedge clk);
          seen = wr_en;
        end
        hold = 1;
        repeat (11) @(negedge clk);
        chk_eq("stall_held", {wr_en, rx_data_ready}, {1'b1, 1'b0});
        hold = 0;
      end
    join
    wait_idle(500);

    build(8'h33, 16'h0, 16'h0, 0);
    send_pkt();
    wait_idle(200);
    chk_eq("mode_reg", mode, 4'h3);

    build(8'h04, 16'h0, 16'h0, 0);
    send_pkt();
    wait_idle(200);

    pkt.delete();
    pkt.push_back(8'h03);
    pkt.push_back(8'h10);
    pkt.push_back(8'h00);
    exp_tx.push_back(8'h18);
    send_pkt();
    wait_idle(TMO + 300);

`ifdef UART_CMD_CSUM_EN
    rand_words(1);
    build(8'h03, 16'h4000, 16'd1, 0);
    send_pkt();
    wait_idle(500);
    rand_words(1);
    build(8'h03, 16'h4000, 16'd1, 1);
    send_pkt();
    wait_idle(500);
`endif

    for (int p = 0; p < 40; p++) begin
      int sel = $urandom_range(0, 9);
      logic [7:0] c;
      logic [15:0] n = 16'($urandom_range(0, 5));
      if (sel < 6) c = {3'b000, 1'($urandom), 4'($urandom_range(1, 4))};
      else if (sel < 8) c = {4'h3, 4'($urandom)};
      else c = 8'($urandom);
      rand_words(int'(n));
      build(c, 16'($urandom), n, ($urandom % 4) == 0);
      send_pkt();
    end
    wait_idle(5000);

    words.delete();
    words.push_back(16'hC0DE);
    build(8'h12, 16'h2000, 16'd200, 0);
    send_pkt();
    begin
      bit seen = 0;
      for (int k = 0; k < 500 && !seen; k++) begin
        @(negedge clk);
        seen = wr_en;
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("mid_rst",
           {wr_en, tx_data_valid, busy, rx_data_ready, mode, mode_stb},
           {1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0});
    exp_wr.delete();
    exp_tx.delete();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_eq("post_rst_quiet", {wr_en, tx_data_valid, busy}, 0);

    rand_words(2);
    build(8'h03, 16'h7FFE, 16'd2, 0);
    send_pkt();
    wait_idle(500);

    chk_eq("left_wr", exp_wr.size(), 0);
    chk_eq("left_tx", exp_tx.size(), 0);
    chk_eq("left_mode", exp_mode.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
